// File: rtl/tpu_host_sequencer.sv
// Host-side job sequencer for the TPU: buffers operands, bursts them in,
// waits for done, captures the result stream and drains it to the host.
module tpu_host_sequencer #(
   parameter int LOAD_BYTES = 8,
   parameter int RES_BYTES  = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       cfg_transpose,
   input  logic       cfg_activation,
   output logic [7:0] tpu_ui_in,
   output logic [7:0] tpu_uio_in,
   input  logic [7:0] tpu_uo_out,
   input  logic       tpu_done,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       busy,
   output logic       timeout_err
);

   localparam int LW = $clog2(LOAD_BYTES);
   localparam int RW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [LW-1:0] L_LAST = LW'(LOAD_BYTES - 1);
   localparam logic [RW-1:0] R_LAST = RW'(RES_BYTES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_BURST,
      S_WAIT,
      S_CAPTURE,
      S_DRAIN
   } state_t;

   state_t        state;
   logic [LW-1:0] ld_idx;
   logic [RW-1:0] rs_idx;
   logic [RW-1:0] rs_nxt;
   logic [TW-1:0] timer;
   logic          cfg_tr;
   logic          cfg_act;
   logic          op_wr;
   logic          rs_wr;

   logic [7:0] op_buf [LOAD_BYTES];
   logic [7:0] rbuf   [RES_BYTES];

   assign s_ready = (state == S_IDLE) || (state == S_FILL);
   assign busy    = (state != S_IDLE);
   assign op_wr   = s_valid && s_ready;
   assign rs_wr   = (state == S_WAIT && tpu_done)
                 || (state == S_CAPTURE);
   assign rs_nxt  = rs_idx + RW'(1);

   // ld_idx is 0 in IDLE, so the first accept lands in op_buf[0]
   always_ff @(posedge clk) begin
      if (op_wr)
         op_buf[ld_idx] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (rs_wr)
         rbuf[rs_idx] <= tpu_uo_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ld_idx      <= '0;
         rs_idx      <= '0;
         timer       <= '0;
         cfg_tr      <= 1'b0;
         cfg_act     <= 1'b0;
         tpu_ui_in   <= '0;
         tpu_uio_in  <= '0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (s_valid) begin
                  cfg_tr      <= cfg_transpose;
                  cfg_act     <= cfg_activation;
                  timeout_err <= 1'b0;
                  ld_idx      <= LW'(1);
                  state       <= S_FILL;
               end
            end
            S_FILL: begin
               if (s_valid) begin
                  if (ld_idx == L_LAST) begin
                     // byte 0 goes out on the same edge, so load_en
                     // and the cfg bits rise together with BURST
                     tpu_ui_in  <= op_buf[0];
                     tpu_uio_in <= {5'b0, cfg_act, cfg_tr, 1'b1};
                     ld_idx     <= LW'(1);
                     state      <= S_BURST;
                  end else begin
                     ld_idx <= ld_idx + LW'(1);
                  end
               end
            end
            S_BURST: begin
               if (ld_idx == '0) begin
                  tpu_ui_in     <= '0;
                  tpu_uio_in[0] <= 1'b0;
                  timer         <= '0;
                  state         <= S_WAIT;
               end else begin
                  tpu_ui_in <= op_buf[ld_idx];
                  ld_idx    <= (ld_idx == L_LAST) ? '0
                                                  : ld_idx + LW'(1);
               end
            end
            S_WAIT: begin
               timer <= timer + TW'(1);
               if (tpu_done) begin
                  if (RES_BYTES == 1) begin
                     m_data  <= tpu_uo_out;
                     m_valid <= 1'b1;
                     m_last  <= 1'b1;
                     rs_idx  <= '0;
                     state   <= S_DRAIN;
                  end else begin
                     rs_idx <= RW'(1);
                     state  <= S_CAPTURE;
                  end
               end else if (timer == T_LAST) begin
                  timeout_err <= 1'b1;
                  tpu_uio_in  <= '0;
                  state       <= S_IDLE;
               end
            end
            S_CAPTURE: begin
               if (rs_idx == R_LAST) begin
                  m_data  <= rbuf[0];
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  rs_idx  <= '0;
                  state   <= S_DRAIN;
               end else begin
                  rs_idx <= rs_nxt;
               end
            end
            S_DRAIN: begin
               if (m_ready) begin
                  if (rs_idx == R_LAST) begin
                     m_data     <= '0;
                     m_valid    <= 1'b0;
                     m_last     <= 1'b0;
                     rs_idx     <= '0;
                     tpu_uio_in <= '0;
                     state      <= S_IDLE;
                  end else begin
                     m_data <= rbuf[rs_nxt];
                     m_last <= (rs_nxt == R_LAST);
                     rs_idx <= rs_nxt;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Bench for tpu_host_sequencer: directed and randomized jobs checked
// against a job-level model of operand, result and timeout behaviour.
module tb_tpu_host_sequencer;

   localparam int LB = 8;
   localparam int RB = 8;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic       cfg_transpose = 1'b0;
   logic       cfg_activation = 1'b0;
   logic [7:0] tpu_ui_in;
   logic [7:0] tpu_uio_in;
   logic [7:0] tpu_uo_out = '0;
   logic       tpu_done = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic       m_last;
   logic       busy;
   logic       timeout_err;

   always #5 clk = ~clk;

   tpu_host_sequencer #(
      .LOAD_BYTES(LB),
      .RES_BYTES (RB),
      .TIMEOUT   (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .cfg_transpose (cfg_transpose),
      .cfg_activation(cfg_activation),
      .tpu_ui_in     (tpu_ui_in),
      .tpu_uio_in    (tpu_uio_in),
      .tpu_uo_out    (tpu_uo_out),
      .tpu_done      (tpu_done),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last        (m_last),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   int n_pass = 0;
   int n_chk  = 0;
   bit exp_terr = 1'b0;
   logic [7:0] op  [LB];
   logic [7:0] res [RB];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic rand_bufs();
      for (int i = 0; i < LB; i++) op[i] = 8'($urandom);
      for (int i = 0; i < RB; i++) res[i] = 8'($urandom);
   endtask

   task automatic feed(input bit tr, input bit act,
                       input bit bub, input bit flip);
      int i = 0;
      int guard = 0;
      while (i < LB && guard < 200) begin
         chk("s_ready_fill", 32'(s_ready), 32'd1);
         chk("tpu_quiet_fill", 32'({tpu_uio_in, tpu_ui_in}), 32'd0);
         chk("terr_fill", 32'(timeout_err),
             32'((i == 0) ? exp_terr : 1'b0));
         if (bub && $urandom_range(1) == 1) begin
            s_valid  = 1'b0;
            s_data   = 8'($urandom);
            tpu_done = 1'($urandom_range(1));
         end else begin
            s_valid  = 1'b1;
            s_data   = op[i];
            tpu_done = 1'b0;
            if (i == 0) begin
               cfg_transpose  = tr;
               cfg_activation = act;
            end else if (flip) begin
               cfg_transpose  = ~tr;
               cfg_activation = ~act;
            end else begin
               cfg_transpose  = 1'($urandom_range(1));
               cfg_activation = 1'($urandom_range(1));
            end
            i++;
         end
         @(negedge clk);
         guard++;
      end
      s_valid        = 1'b0;
      tpu_done       = 1'b0;
      cfg_transpose  = ~tr;
      cfg_activation = ~act;
   endtask

   task automatic burst(input bit tr, input bit act);
      int n = 0;
      chk("s_ready_burst", 32'(s_ready), 32'd0);
      while (tpu_uio_in[0] === 1'b1 && n < LB + 2) begin
         if (n < LB) chk("burst_byte", 32'(tpu_ui_in), 32'(op[n]));
         chk("burst_cfg", 32'(tpu_uio_in[7:1]), 32'({5'b0, act, tr}));
         n++;
         @(negedge clk);
      end
      chk("burst_len", 32'(n), 32'(LB));
      chk("wait_quiet", 32'({tpu_uio_in[0], tpu_ui_in}), 32'd0);
   endtask

   // j = WAIT cycle on which the TPU raises done; j >= TO means never
   task automatic tpu_side(input bit tr, input bit act, input int j);
      int c = 0;
      while (c < j && c < TO) begin
         chk("busy_wait", 32'(busy), 32'd1);
         chk("mv_wait", 32'(m_valid), 32'd0);
         chk("uio_wait", 32'(tpu_uio_in), 32'({5'b0, act, tr, 1'b0}));
         tpu_uo_out = 8'($urandom);
         @(negedge clk);
         c++;
      end
      if (j < TO) begin
         tpu_done = 1'b1;
         for (int r = 0; r < RB; r++) begin
            tpu_uo_out = res[r];
            chk("mv_capture", 32'(m_valid), 32'd0);
            @(negedge clk);
         end
         tpu_done   = 1'b0;
         tpu_uo_out = 8'($urandom);
      end else begin
         chk("to_busy", 32'(busy), 32'd0);
         chk("to_err", 32'(timeout_err), 32'd1);
         chk("to_mv", 32'(m_valid), 32'd0);
         chk("to_uio", 32'(tpu_uio_in), 32'd0);
         exp_terr = 1'b1;
         tpu_done = 1'b1;
         for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("late_done_mv", 32'(m_valid), 32'd0);
            chk("late_done_busy", 32'(busy), 32'd0);
         end
         tpu_done = 1'b0;
      end
   endtask

   // stall < 0: random m_ready; otherwise hold 3 cycles on that index
   task automatic drain(input bit tr, input bit act, input int stall);
      int k = 0;
      int cyc = 0;
      int held = 0;
      while (k < RB && cyc < 16 * RB) begin
         bit rdy;
         chk("m_valid", 32'(m_valid), 32'd1);
         chk("m_data", 32'(m_data), 32'(res[k]));
         chk("m_last", 32'(m_last), 32'(k == RB - 1));
         chk("uio_drain", 32'(tpu_uio_in), 32'({5'b0, act, tr, 1'b0}));
         if (stall >= 0) begin
            rdy = !(k == stall && held < 3);
            if (!rdy) held++;
         end else begin
            rdy = 1'($urandom_range(1));
         end
         m_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) k++;
      end
      m_ready = 1'b0;
      chk("drain_count", 32'(k), 32'(RB));
      chk("end_mv", 32'(m_valid), 32'd0);
      chk("end_last", 32'(m_last), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_uio", 32'(tpu_uio_in), 32'd0);
      chk("end_s_ready", 32'(s_ready), 32'd1);
      chk("end_terr", 32'(timeout_err), 32'd0);
      exp_terr = 1'b0;
   endtask

   task automatic run_job(input bit tr, input bit act, input bit bub,
                          input bit flip, input int j, input int stall);
      feed(tr, act, bub, flip);
      burst(tr, act);
      tpu_side(tr, act, j);
      if (j < TO) drain(tr, act, stall);
   endtask

   initial begin
      #12;
      chk("rst_ui", 32'(tpu_ui_in), 32'd0);
      chk("rst_uio", 32'(tpu_uio_in), 32'd0);
      chk("rst_m", 32'({m_valid, m_last, m_data}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rel_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < LB; i++) op[i] = 8'(i + 1);
      for (int i = 0; i < RB; i++) res[i] = 8'(8'h11 + i);
      run_job(1'b0, 1'b0, 1'b0, 1'b0, 5, 99);

      rand_bufs();
      run_job(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1,
              1'b0, 32'($urandom_range(TO - 1)), -1);

      rand_bufs();
      for (int i = 0; i < RB; i++) res[i] = 8'(8'h11 + i);
      run_job(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);

      rand_bufs();
      run_job(1'b1, 1'b0, 1'b0, 1'b0, TO, -1);

      rand_bufs();
      run_job(1'b0, 1'b1, 1'b1, 1'b0, TO - 1, -1);

      rand_bufs();
      run_job(1'b1, 1'b1, 1'b1, 1'b1, 7, -1);

      rand_bufs();
      feed(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_burst_load", 32'(tpu_uio_in[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_uio", 32'(tpu_uio_in), 32'd0);
      chk("async_ui", 32'(tpu_ui_in), 32'd0);
      chk("async_mv", 32'(m_valid), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_terr = 1'b0;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      rand_bufs();
      run_job(1'b0, 1'b0, 1'b0, 1'b0, 1, -1);

      for (int n = 0; n < 8; n++) begin
         rand_bufs();
         run_job(1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)),
                 32'($urandom_range(TO + 1)), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
Host-side driver that sits directly upstream and downstream of the TPU top level. It sequences one complete job:
- Collects operand bytes from a valid/ready host stream into an operand buffer.
- Replays them to the TPU as one contiguous load_en burst.
- Waits for the TPU done flag, with a timeout.
- Captures the TPU's un-throttled result byte stream into a result buffer.
- Drains the results to the host over a valid/ready stream with last marking.

Parameters:
LOAD_BYTES, 8, operand bytes per job (4 weights + 4 inputs); must be ≥2.
RES_BYTES, 8, result bytes the TPU emits per job; must be ≥1.
TIMEOUT, 255, WAIT cycles allowed before abort; must be ≥1.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
s_data  in  8  operand byte from host
s_valid  in  1  operand byte valid
s_ready  out  1  sequencer accepts operand byte
cfg_transpose  in  1  job transpose flag, sampled with first accepted byte
cfg_activation  in  1  job activation flag, sampled with first accepted byte
tpu_ui_in  out  8  to TPU data input
tpu_uio_in  out  8  to TPU control input: {5'b0, activation, transpose, load_en}
tpu_uo_out  in  8  TPU result byte
tpu_done  in  1  TPU done (its uio_out[7])
m_data  out  8  result byte to host
m_valid  out  1  result byte valid
m_ready  in  1  host accepts result byte
m_last  out  1  final result byte of job
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky abort flag; cleared by next accepted first byte

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; all counters = 0.
  - tpu_ui_in = 0, tpu_uio_in = 0, m_valid = 0, m_last = 0, m_data = 0, busy = 0, timeout_err = 0.
  - s_ready = 1 after reset release.
- All tpu_* and m_* outputs are registered.
- State IDLE:
  - s_ready = 1.
  - Accepted byte (s_valid & s_ready) → buf[0]; latch cfg_transpose/cfg_activation; clear timeout_err; go to FILL with idx = 1.
- State FILL:
  - s_ready = 1; each accepted byte → buf[idx], idx++.
  - Host bubbles are allowed and have no effect on the TPU.
  - On the accept with idx = LOAD_BYTES-1 → BURST, idx = 0.
- State BURST:
  - s_ready = 0.
  - Exactly LOAD_BYTES consecutive cycles with load_en = 1 and tpu_ui_in = buf[0..LOAD_BYTES-1] in order. No gaps are permitted.
  - The cycle after the last byte: load_en = 0, tpu_ui_in = 0, go to WAIT, timer = 0.
- State WAIT:
  - Timer increments each cycle.
  - tpu_done sampled high → capture tpu_uo_out as rbuf[0]. If RES_BYTES = 1, go to DRAIN; otherwise go to CAPTURE with idx = 1.
  - If the timer reaches TIMEOUT with done still low: timeout_err = 1, go to IDLE, emit no output.
  - If done and timeout coincide, done wins.
- State CAPTURE:
  - Sample tpu_uo_out into rbuf[idx] every cycle, with no stall. The TPU has no backpressure.
  - After idx = RES_BYTES-1 → DRAIN, idx = 0.
- State DRAIN:
  - m_valid = 1, m_data = rbuf[idx], m_last = (idx == RES_BYTES-1).
  - idx advances only on m_valid & m_ready; m_data and m_last stay stable while stalled.
  - Handshake with m_last → IDLE, m_valid = 0 next cycle.
- Transpose/activation bits:
  - tpu_uio_in[2:1] hold the latched cfg values from BURST start until return to IDLE.
  - They are 0 in IDLE and FILL.
- Mid-job events:
  - cfg_* changes after the first byte are ignored.
  - tpu_done pulses outside WAIT are ignored.
- Reset mid-job aborts immediately. tpu_uio_in goes to 0 asynchronously, so load_en is never left high. Buffers need not be cleared.

Test Plan:
- Basic job:
  - Stimulus: bytes 0x01..0x08 back-to-back, cfg 0/0; done raised 5 cycles after burst with tpu_uo_out = 0x11..0x18 on consecutive cycles.
  - Required response: load_en high exactly 8 consecutive cycles with ui_in = 0x01..0x08; m stream emits 0x11..0x18 with m_last on 0x18; busy low afterward.
- Host bubbles:
  - Stimulus: s_valid toggled 1/0 during FILL.
  - Required response: burst still 8 contiguous load_en cycles with correct order; no TPU activity before the 8th accept.
- Result backpressure:
  - Stimulus: m_ready held low 3 cycles on byte 2.
  - Required response: m_data = 0x13 stable throughout the stall; all 8 bytes delivered in order, none lost or duplicated.
- Timeout:
  - Stimulus: TIMEOUT = 20, tpu_done held low.
  - Required response: timeout_err = 1 after 20 WAIT cycles, state IDLE, m_valid never asserted; the next job's first accepted byte clears timeout_err.
- Config latch:
  - Stimulus: cfg_transpose = 1, cfg_activation = 1 at first byte, both changed to 0 mid-FILL.
  - Required response: tpu_uio_in[2:1] = 2'b11 from BURST through DRAIN, 0 in IDLE.
- Reset mid-job:
  - Stimulus: rst asserted during BURST.
  - Required response: tpu_uio_in = 0 and m_valid = 0 without waiting for a clock edge; s_ready = 1 after release; next full job completes correctly.
